// File: rtl/dsp_post_adder_accum.sv
// DSP48A1 post-adder/accumulator: OPMODE-selected X/Z operands, Z +/- (X + CIN),
// optional P/CARRYOUT register with accumulator feedback and cascade output.
module dsp_post_adder_accum #(
  parameter int    WIDTH      = 48,
  parameter int    MWIDTH     = 36,
  parameter bit    OPMODEREG  = 1'b1,
  parameter bit    CARRYINREG = 1'b1,
  parameter bit    PREG       = 1'b1,
  parameter string CARRYINSEL = "OPMODE5"
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CEOPMODE,
  input  logic              CECARRYIN,
  input  logic              CEP,
  input  logic [7:0]        OPMODE,
  input  logic [MWIDTH-1:0] M,
  input  logic [WIDTH-1:0]  DAB,
  input  logic [WIDTH-1:0]  C,
  input  logic [WIDTH-1:0]  PCIN,
  input  logic              CARRYIN,
  output logic [WIDTH-1:0]  P,
  output logic [WIDTH-1:0]  PCOUT,
  output logic              CARRYOUT,
  output logic              CARRYOUTF
);

  localparam bit CIN_FROM_PORT = (CARRYINSEL == "CARRYIN");

  logic [7:0]       r_opmode;
  logic             r_cin;
  logic [WIDTH-1:0] r_p;
  logic             r_carry;

  logic [7:0]       w_opm;
  logic             w_cin_src;
  logic             w_cin;
  logic [WIDTH-1:0] w_m_ext;
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_z;
  logic [WIDTH:0]   w_sum;
  logic             w_unused;

  assign w_opm     = OPMODEREG ? r_opmode : OPMODE;
  assign w_unused  = ^{w_opm[6], w_opm[4]};
  assign w_m_ext   = {{(WIDTH-MWIDTH){M[MWIDTH-1]}}, M};
  assign w_cin_src = CIN_FROM_PORT ? CARRYIN : w_opm[5];
  assign w_cin     = CARRYINREG ? r_cin : w_cin_src;

  // Without a P register, a P select would close a combinational loop; read it as zero.
  always_comb begin
    w_x = '0;
    case (w_opm[1:0])
      2'd0: w_x = '0;
      2'd1: w_x = w_m_ext;
      2'd2: w_x = PREG ? r_p : '0;
      2'd3: w_x = DAB;
    endcase
  end

  always_comb begin
    w_z = '0;
    case (w_opm[3:2])
      2'd0: w_z = '0;
      2'd1: w_z = PCIN;
      2'd2: w_z = PREG ? r_p : '0;
      2'd3: w_z = C;
    endcase
  end

  // Top bit is carry when adding and borrow when subtracting.
  always_comb begin
    if (w_opm[7])
      w_sum = {1'b0, w_z} - ({1'b0, w_x} + {{WIDTH{1'b0}}, w_cin});
    else
      w_sum = {1'b0, w_z} + {1'b0, w_x} + {{WIDTH{1'b0}}, w_cin};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)           r_opmode <= '0;
    else if (CEOPMODE) r_opmode <= OPMODE;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)            r_cin <= 1'b0;
    else if (CECARRYIN) r_cin <= w_cin_src;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_p     <= '0;
      r_carry <= 1'b0;
    end else if (CEP) begin
      r_p     <= w_sum[WIDTH-1:0];
      r_carry <= w_sum[WIDTH];
    end
  end

  assign P         = PREG ? r_p     : w_sum[WIDTH-1:0];
  assign CARRYOUT  = PREG ? r_carry : w_sum[WIDTH];
  assign PCOUT     = P;
  assign CARRYOUTF = CARRYOUT;

endmodule

// File: tb/tb_dsp_post_adder_accum.sv
// Bench for dsp_post_adder_accum: directed test-plan steps then random cycles,
// checked against an arithmetic reference of three parameterisations.
module tb_dsp_post_adder_accum;

  localparam longint unsigned MASK48 = 64'h0000_FFFF_FFFF_FFFF;
  localparam longint unsigned TWO48  = 64'h0001_0000_0000_0000;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CEOPMODE = 1'b1, CECARRYIN = 1'b1, CEP = 1'b1;
  logic [7:0]  OPMODE = '0;
  logic [35:0] M = '0;
  logic [47:0] DAB = '0, C = '0, PCIN = '0;
  logic        CARRYIN = 1'b0;

  logic [47:0] p0, pc0, p1, pc1, p2, pc2;
  logic        co0, cof0, co1, cof1, co2, cof2;

  int checks = 0;
  int failures = 0;

  // model state for the two registered instances (0: OPMODE5 carry, 1: CARRYIN port)
  logic [7:0]  m_opm [2];
  logic        m_cin [2];
  logic [47:0] m_p   [2];
  logic        m_co  [2];

  always #5 CLK = ~CLK;

  dsp_post_adder_accum u_reg (
    .CLK(CLK), .RST(RST), .CEOPMODE(CEOPMODE), .CECARRYIN(CECARRYIN), .CEP(CEP),
    .OPMODE(OPMODE), .M(M), .DAB(DAB), .C(C), .PCIN(PCIN), .CARRYIN(CARRYIN),
    .P(p0), .PCOUT(pc0), .CARRYOUT(co0), .CARRYOUTF(cof0));

  dsp_post_adder_accum #(.CARRYINSEL("CARRYIN")) u_cy (
    .CLK(CLK), .RST(RST), .CEOPMODE(CEOPMODE), .CECARRYIN(CECARRYIN), .CEP(CEP),
    .OPMODE(OPMODE), .M(M), .DAB(DAB), .C(C), .PCIN(PCIN), .CARRYIN(CARRYIN),
    .P(p1), .PCOUT(pc1), .CARRYOUT(co1), .CARRYOUTF(cof1));

  dsp_post_adder_accum #(.OPMODEREG(1'b0), .CARRYINREG(1'b0), .PREG(1'b0)) u_byp (
    .CLK(CLK), .RST(RST), .CEOPMODE(CEOPMODE), .CECARRYIN(CECARRYIN), .CEP(CEP),
    .OPMODE(OPMODE), .M(M), .DAB(DAB), .C(C), .PCIN(PCIN), .CARRYIN(CARRYIN),
    .P(p2), .PCOUT(pc2), .CARRYOUT(co2), .CARRYOUTF(cof2));

  function automatic longint unsigned operand(logic [1:0] sel, bit is_x, logic [47:0] p, bit preg);
    case (sel)
      2'd0: return 0;
      2'd1: return is_x ? (longint'($signed(M)) & MASK48) : longint'(PCIN);
      2'd2: return preg ? longint'(p) : 0;
      default: return is_x ? longint'(DAB) : longint'(C);
    endcase
  endfunction

  // Returns {carry/borrow, result} using ordinary integer arithmetic.
  function automatic logic [48:0] calc(logic [7:0] opm, logic cin, logic [47:0] p, bit preg);
    longint unsigned x, z, t;
    longint d;
    x = operand(opm[1:0], 1'b1, p, preg);
    z = operand(opm[3:2], 1'b0, p, preg);
    if (opm[7]) begin
      d = longint'(z) - longint'(x) - longint'(cin);
      return {d < 0, d[47:0]};
    end
    t = z + x + longint'(cin);
    return {t >= TWO48, t[47:0]};
  endfunction

  task automatic chk(string tag, logic [48:0] obs, logic [48:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_opm[k] = '0; m_cin[k] = 1'b0; m_p[k] = '0; m_co[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    logic [48:0] r;
    if (RST) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      r = calc(m_opm[k], m_cin[k], m_p[k], 1'b1);
      if (CEP) begin m_p[k] = r[47:0]; m_co[k] = r[48]; end
      if (CECARRYIN) m_cin[k] = (k == 1) ? CARRYIN : m_opm[k][5];
      if (CEOPMODE) m_opm[k] = OPMODE;
    end
  endtask

  task automatic chk_byp();
    logic [48:0] e;
    e = calc(OPMODE, OPMODE[5], 48'h0, 1'b0);
    chk("byp_p", {co2, p2}, e);
    chk("byp_cas", {cof2, pc2}, e);
  endtask

  task automatic chk_reg();
    chk("reg_p",   {co0, p0},   {m_co[0], m_p[0]});
    chk("reg_cas", {cof0, pc0}, {m_co[0], m_p[0]});
    chk("cy_p",    {co1, p1},   {m_co[1], m_p[1]});
    chk("cy_cas",  {cof1, pc1}, {m_co[1], m_p[1]});
  endtask

  // Inputs are stable here (1 after posedge); check bypass, clock, check registered.
  task automatic cyc();
    #1 chk_byp();
    @(posedge CLK);
    model_edge();
    #1 chk_reg();
  endtask

  initial begin
    model_reset();
    // reset held across edges with all enables high
    #2;
    chk("rst_p0", {co0, p0}, 49'h0);
    chk("rst_p1", {co1, p1}, 49'h0);
    OPMODE = 8'h0D; M = 36'd5; C = 48'd100;
    cyc(); cyc();
    chk("rst_hold", {co0, p0}, 49'h0);
    chk("rst_opm", {41'h0, u_reg.r_opmode}, 49'h0);
    @(negedge CLK) RST = 1'b0;

    // add path: opmode loads on first edge, P=105 on the next
    cyc(); cyc();
    chk("add_105", {co0, p0}, {1'b0, 48'd105});

    // accumulate from reset, with one CEP-low hold
    @(negedge CLK) RST = 1'b1;
    #1 model_reset();
    @(negedge CLK) RST = 1'b0;
    OPMODE = 8'h09; M = 36'd3;
    cyc();
    chk("acc_0", {co0, p0}, 49'd0);
    cyc(); chk("acc_3", {co0, p0}, 49'd3);
    cyc(); chk("acc_6", {co0, p0}, 49'd6);
    CEP = 1'b0;
    cyc(); chk("acc_hold", {co0, p0}, 49'd6);
    CEP = 1'b1;
    cyc(); chk("acc_9", {co0, p0}, 49'd9);
    cyc(); chk("acc_12", {co0, p0}, 49'd12);

    // async reset between edges
    #2 RST = 1'b1;
    #1;
    model_reset();
    chk("arst_p", {co0, p0}, 49'h0);
    chk("arst_cas", {cof0, pc0}, 49'h0);
    chk("arst_opm", {41'h0, u_reg.r_opmode}, 49'h0);
    #1 RST = 1'b0;
    cyc(); chk("restart_0", {co0, p0}, 49'd0);
    cyc(); chk("restart_3", {co0, p0}, 49'd3);

    // subtract with borrow, then without
    OPMODE = 8'h8D; C = 48'd10; M = 36'd20;
    cyc(); cyc();
    chk("sub_neg", {co0, p0}, {1'b1, 48'hFFFF_FFFF_FFF6});
    C = 48'd20; M = 36'd10;
    cyc();
    chk("sub_pos", {co0, p0}, {1'b0, 48'd10});

    // wrap: carry-in reaches the adder one edge after the opmode register
    OPMODE = 8'h2F; DAB = 48'hFFFF_FFFF_FFFF; C = 48'h0; CARRYIN = 1'b0;
    cyc(); cyc(); cyc();
    chk("wrap_op5", {co0, p0}, {1'b1, 48'h0});
    chk("wrap_cyport", {co1, p1}, {1'b0, 48'hFFFF_FFFF_FFFF});

    // bypass: same-cycle update, X=P reads as zero
    OPMODE = 8'h0D; M = 36'd5; C = 48'd100;
    #1 chk("byp_105", {co2, p2}, {1'b0, 48'd105});
    OPMODE = 8'h0E; C = 48'd77;
    #1 chk("byp_xp", {co2, p2}, {1'b0, 48'd77});
    M = 36'hF_FFFF_FFFF; OPMODE = 8'h05; PCIN = 48'd1;
    #1 chk("byp_mneg", {co2, p2}, {1'b1, 48'd0});
    @(negedge CLK);

    // random traffic, occasionally pulsing reset
    for (int i = 0; i < 400; i++) begin
      OPMODE    = 8'($urandom);
      M         = {4'($urandom), 32'($urandom)};
      DAB       = ($urandom_range(0, 7) == 0) ? 48'hFFFF_FFFF_FFFF : {16'($urandom), 32'($urandom)};
      C         = {16'($urandom), 32'($urandom)};
      PCIN      = {16'($urandom), 32'($urandom)};
      CARRYIN   = 1'($urandom);
      CEOPMODE  = ($urandom_range(0, 3) != 0);
      CECARRYIN = ($urandom_range(0, 3) != 0);
      CEP       = ($urandom_range(0, 4) != 0);
      RST       = ($urandom_range(0, 49) == 0);
      cyc();
      @(negedge CLK);
    end
    RST = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
